// File: rtl/if_fetch_btb.sv
// Instruction-fetch front end: the PC register plus a direct-mapped BTB
// with 2-bit saturating counters, trained by the branch-resolution stage.
module if_fetch_btb #(
  parameter int          IDX_BITS = 3,
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        CLK,
  input  logic        CLR_N,
  input  logic        En,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
  input  logic        Upd_Valid,
  input  logic [31:0] Upd_PC,
  input  logic [31:0] Upd_Target,
  input  logic        Upd_Taken,
  output logic [31:0] PC,
  output logic [31:0] PC_plus_four,
  output logic        PredictJump,
  output logic [31:0] PredTarget,
  output logic        Hit
);

  localparam int ENTRIES  = 1 << IDX_BITS;
  localparam int TAG_BITS = 32 - IDX_BITS - 2;

  logic                btb_valid  [ENTRIES];
  logic [TAG_BITS-1:0] btb_tag    [ENTRIES];
  logic [31:0]         btb_target [ENTRIES];
  logic [1:0]          btb_ctr    [ENTRIES];

  logic [IDX_BITS-1:0] look_idx;
  logic [TAG_BITS-1:0] look_tag;
  logic [IDX_BITS-1:0] upd_idx;
  logic [TAG_BITS-1:0] upd_tag;
  logic                upd_hit;
  logic [31:0]         next_pc;
  logic                unused_upd_bits;

  // Byte-offset bits of the training PC carry no index or tag information.
  assign unused_upd_bits = ^Upd_PC[1:0];

  assign look_idx = PC[IDX_BITS+1:2];
  assign look_tag = PC[31:IDX_BITS+2];
  assign upd_idx  = Upd_PC[IDX_BITS+1:2];
  assign upd_tag  = Upd_PC[31:IDX_BITS+2];

  always_comb begin
    Hit          = btb_valid[look_idx] && (btb_tag[look_idx] == look_tag);
    PredictJump  = Hit && btb_ctr[look_idx][1];
    PredTarget   = Hit ? btb_target[look_idx] : 32'h0;
    PC_plus_four = PC + 32'd4;
    upd_hit      = btb_valid[upd_idx] && (btb_tag[upd_idx] == upd_tag);
  end

  always_comb begin
    next_pc = PC_plus_four;
    if (Redirect)
      next_pc = RedirectPC;
    else if (!En)
      next_pc = PC;
    else if (PredictJump)
      next_pc = PredTarget;
  end

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N)
      PC <= RESET_PC;
    else
      PC <= next_pc;
  end

  // Training writes land at the edge, so a same-cycle lookup sees old contents.
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb_valid[i]  <= 1'b0;
        btb_tag[i]    <= '0;
        btb_target[i] <= 32'h0;
        btb_ctr[i]    <= 2'b00;
      end
    end else if (Upd_Valid) begin
      if (upd_hit) begin
        if (Upd_Taken) begin
          btb_target[upd_idx] <= Upd_Target;
          if (btb_ctr[upd_idx] != 2'b11)
            btb_ctr[upd_idx] <= btb_ctr[upd_idx] + 2'b01;
        end else if (btb_ctr[upd_idx] != 2'b00) begin
          btb_ctr[upd_idx] <= btb_ctr[upd_idx] - 2'b01;
        end
      end else if (Upd_Taken) begin
        btb_valid[upd_idx]  <= 1'b1;
        btb_tag[upd_idx]    <= upd_tag;
        btb_target[upd_idx] <= Upd_Target;
        btb_ctr[upd_idx]    <= 2'b10;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_btb.sv
// Directed, table-driven bench for if_fetch_btb with hand-computed
// expectations, plus a hand-written asynchronous-reset sequence.
module tb_if_fetch_btb;

  logic        clk;
  logic        clrN;
  logic        en;
  logic        redirect;
  logic [31:0] redirectPc;
  logic        updValid;
  logic [31:0] updPc;
  logic [31:0] updTarget;
  logic        updTaken;
  logic [31:0] pc;
  logic [31:0] pcPlusFour;
  logic        predictJump;
  logic [31:0] predTarget;
  logic        hit;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic        en;
    logic        redirect;
    logic [31:0] redirectPc;
    logic        updValid;
    logic [31:0] updPc;
    logic [31:0] updTarget;
    logic        updTaken;
    logic [31:0] expPc;
    logic        expPj;
    logic        expHit;
    logic [31:0] expPt;
  } vec_t;

  localparam int NVEC = 27;
  vec_t vecs [NVEC];

  if_fetch_btb dut (
    .CLK          (clk),
    .CLR_N        (clrN),
    .En           (en),
    .Redirect     (redirect),
    .RedirectPC   (redirectPc),
    .Upd_Valid    (updValid),
    .Upd_PC       (updPc),
    .Upd_Target   (updTarget),
    .Upd_Taken    (updTaken),
    .PC           (pc),
    .PC_plus_four (pcPlusFour),
    .PredictJump  (predictJump),
    .PredTarget   (predTarget),
    .Hit          (hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic e, logic r, logic [31:0] rpc,
                              logic uv, logic [31:0] upc, logic [31:0] utgt, logic ut,
                              logic [31:0] xpc, logic xpj, logic xhit, logic [31:0] xpt);
    vec_t v;
    v.en = e; v.redirect = r; v.redirectPc = rpc;
    v.updValid = uv; v.updPc = upc; v.updTarget = utgt; v.updTaken = ut;
    v.expPc = xpc; v.expPj = xpj; v.expHit = xhit; v.expPt = xpt;
    return v;
  endfunction

  task automatic check32(string name, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput(string tag, logic [31:0] xpc, logic xpj, logic xhit, logic [31:0] xpt);
    check32({tag, " PC"}, pc, xpc);
    check32({tag, " PC_plus_four"}, pcPlusFour, xpc + 32'd4);
    check32({tag, " PredictJump"}, {31'b0, predictJump}, {31'b0, xpj});
    check32({tag, " Hit"}, {31'b0, hit}, {31'b0, xhit});
    check32({tag, " PredTarget"}, predTarget, xpt);
  endtask

  task automatic applyStimulus(vec_t v);
    en = v.en; redirect = v.redirect; redirectPc = v.redirectPc;
    updValid = v.updValid; updPc = v.updPc; updTarget = v.updTarget; updTaken = v.updTaken;
  endtask

  initial begin
    // Expected values are the registered state after the edge following each vector.
    vecs[0]  = mk(1, 0, 0,     0, 0,    0,     0, 32'h04, 0, 0, 0);
    vecs[1]  = mk(1, 0, 0,     0, 0,    0,     0, 32'h08, 0, 0, 0);
    vecs[2]  = mk(1, 0, 0,     0, 0,    0,     0, 32'h0C, 0, 0, 0);
    vecs[3]  = mk(1, 0, 0,     1, 'h10, 'h40,  1, 32'h10, 1, 1, 32'h40);
    vecs[4]  = mk(1, 0, 0,     0, 0,    0,     0, 32'h40, 0, 0, 0);
    vecs[5]  = mk(1, 1, 'h10,  1, 'h10, 'h99,  0, 32'h10, 0, 1, 32'h40);
    vecs[6]  = mk(1, 0, 0,     1, 'h10, 'h99,  0, 32'h14, 0, 0, 0);
    vecs[7]  = mk(1, 1, 'h10,  0, 0,    0,     0, 32'h10, 0, 1, 32'h40);
    vecs[8]  = mk(0, 0, 0,     1, 'h10, 'h80,  1, 32'h10, 0, 1, 32'h80);
    vecs[9]  = mk(0, 0, 0,     1, 'h10, 'h80,  1, 32'h10, 1, 1, 32'h80);
    vecs[10] = mk(1, 0, 0,     1, 'h10, 'h90,  1, 32'h80, 0, 0, 0);
    vecs[11] = mk(1, 1, 'h30,  0, 0,    0,     0, 32'h30, 0, 0, 0);
    vecs[12] = mk(1, 0, 0,     0, 0,    0,     0, 32'h34, 0, 0, 0);
    vecs[13] = mk(1, 1, 'h10,  0, 0,    0,     0, 32'h10, 1, 1, 32'h90);
    vecs[14] = mk(1, 0, 0,     1, 'h10, 0,     0, 32'h90, 0, 0, 0);
    vecs[15] = mk(1, 1, 'h10,  0, 0,    0,     0, 32'h10, 1, 1, 32'h90);
    vecs[16] = mk(0, 0, 0,     1, 'h30, 'h200, 1, 32'h10, 0, 0, 0);
    vecs[17] = mk(1, 0, 0,     0, 0,    0,     0, 32'h14, 0, 0, 0);
    vecs[18] = mk(1, 1, 'h30,  0, 0,    0,     0, 32'h30, 1, 1, 32'h200);
    vecs[19] = mk(0, 0, 0,     1, 'h50, 'h300, 0, 32'h30, 1, 1, 32'h200);
    vecs[20] = mk(1, 1, 'h20,  0, 0,    0,     0, 32'h20, 0, 0, 0);
    vecs[21] = mk(0, 0, 0,     0, 0,    0,     0, 32'h20, 0, 0, 0);
    vecs[22] = mk(0, 0, 0,     0, 0,    0,     0, 32'h20, 0, 0, 0);
    vecs[23] = mk(0, 1, 'h100, 0, 0,    0,     0, 32'h100, 0, 0, 0);
    vecs[24] = mk(1, 1, 32'hFFFFFFFC, 0, 0, 0, 0, 32'hFFFFFFFC, 0, 0, 0);
    vecs[25] = mk(1, 0, 0,     0, 0,    0,     0, 32'h0, 0, 0, 0);
    vecs[26] = mk(1, 1, 'h100, 0, 0,    0,     0, 32'h100, 0, 0, 0);

    clrN = 1'b0;
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(negedge clk);
    checkOutput("reset", 32'h0, 0, 0, 32'h0);
    clrN = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i]);
      @(posedge clk);
      @(negedge clk);
      checkOutput($sformatf("vec%0d", i), vecs[i].expPc, vecs[i].expPj, vecs[i].expHit, vecs[i].expPt);
    end

    // Retrain 0x10, then reset between edges while a training strobe is still up.
    applyStimulus(mk(0, 0, 0, 1, 'h10, 'h40, 1, 0, 0, 0, 0));
    @(posedge clk);
    @(negedge clk);
    checkOutput("pre-reset", 32'h100, 0, 0, 32'h0);
    #2;
    clrN = 1'b0;
    #1;
    checkOutput("async reset", 32'h0, 0, 0, 32'h0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("held reset", 32'h0, 0, 0, 32'h0);
    applyStimulus(mk(1, 1, 'h10, 0, 0, 0, 0, 0, 0, 0, 0));
    clrN = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("post-reset 0x10", 32'h10, 0, 0, 32'h0);
    applyStimulus(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    @(negedge clk);
    checkOutput("post-reset seq", 32'h14, 0, 0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
